datapath_sequencer: RTL and testbench

- Micro-sequencer for the 4-bit register/memory datapath: R1, R2, AR, 16-word memory, two 4:1 bus muxes, add/sub ALU.
- Accepts one command per valid/ready handshake and expands it into 1–2 datapath cycles.
- Drives every datapath control: register loads, bus selects, ALU function, memory read/write, and the external operand bus x.
- Sits between a command source (switch panel or test driver) and the datapath top level. It replaces hand-driven control switches.

---
 rtl/datapath_sequencer_pkg.sv | 47 ++++
 rtl/datapath_sequencer_seq_decode.sv | 109 ++++++++++
 rtl/datapath_sequencer.sv | 117 +++++++++++
 tb/tb_datapath_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_sequencer_pkg.sv
// Shared definitions for the datapath micro-sequencer.
//   - opcode constants (OP_LDI .. OP_CLRM)
//   - bus select codes for s1/s2 (SEL_X, SEL_R1, SEL_R2, SEL_MEM)
//   - destination register codes (DST_R1, DST_R2, DST_AR, DST_BAD)
//   - FSM state enum
//   - helpers that classify a latched command (illegal / two-step)
package datapath_sequencer_pkg;

    localparam logic [2:0] OP_LDI   = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b001;
    localparam logic [2:0] OP_SUB   = 3'b010;
    localparam logic [2:0] OP_LD    = 3'b011;
    localparam logic [2:0] OP_ST    = 3'b100;
    localparam logic [2:0] OP_ADDI  = 3'b101;
    localparam logic [2:0] OP_LDINC = 3'b110;
    localparam logic [2:0] OP_CLRM  = 3'b111;

    localparam logic [1:0] SEL_X   = 2'd0;
    localparam logic [1:0] SEL_R1  = 2'd1;
    localparam logic [1:0] SEL_R2  = 2'd2;
    localparam logic [1:0] SEL_MEM = 2'd3;

    localparam logic [1:0] DST_R1  = 2'd0;
    localparam logic [1:0] DST_R2  = 2'd1;
    localparam logic [1:0] DST_AR  = 2'd2;
    localparam logic [1:0] DST_BAD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STEP1 = 2'd1,
        ST_STEP2 = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    // AR is not a bus source, so ops that read dst as an operand cannot
    // target it; dst code 3 is never valid.
    function automatic logic cmd_illegal(input logic [2:0] op, input logic [1:0] dst);
        logic reads_dst;
        reads_dst = (op == OP_LDI) || (op == OP_ADDI) || (op == OP_LDINC) || (op == OP_ST);
        return (dst == DST_BAD) || ((dst == DST_AR) && reads_dst);
    endfunction

    function automatic logic cmd_two_step(input logic [2:0] op);
        return (op == OP_LDI) || (op == OP_LDINC);
    endfunction

endpackage

// File: rtl/datapath_sequencer_seq_decode.sv
// Combinational control-word decoder.
// Maps {state, latched op, dst, imm, illegal flag} to the datapath controls.
//   state   : current sequencer state (controls only active in STEP1/STEP2)
//   op/dst/imm : latched command fields
//   illegal : latched command is illegal -> all controls stay inactive
//   x       : operand onto bus source 0
//   l1/l2/l3: load enables R1/R2/AR
//   s1/s2   : bus selects, f : 0=add 1=sub, w/r : memory strobes
module datapath_sequencer_seq_decode
    import datapath_sequencer_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  state_t             state,
    input  logic [2:0]         op,
    input  logic [1:0]         dst,
    input  logic [WIDTH-1:0]   imm,
    input  logic               illegal,
    output logic [WIDTH-1:0]   x,
    output logic               l1,
    output logic               l2,
    output logic               l3,
    output logic [1:0]         s1,
    output logic [1:0]         s2,
    output logic               f,
    output logic               w,
    output logic               r
);

    logic       ld_en;
    logic       step2;
    logic [1:0] dst_sel;
    logic [2:0] dst_onehot;

    // Bus select that reads dst; only meaningful for R1/R2 (legal cases).
    assign dst_sel    = (dst == DST_R2) ? SEL_R2 : SEL_R1;
    assign dst_onehot = 3'b001 << dst;
    assign step2      = (state == ST_STEP2);

    always_comb begin
        x     = '0;
        ld_en = 1'b0;
        s1    = SEL_X;
        s2    = SEL_X;
        f     = 1'b0;
        w     = 1'b0;
        r     = 1'b0;
        if (((state == ST_STEP1) || (state == ST_STEP2)) && !illegal) begin
            case (op)
                OP_LDI: begin
                    // Clear via dst-dst, then add the immediate onto zero.
                    ld_en = 1'b1;
                    s1    = dst_sel;
                    if (!step2) begin
                        s2 = dst_sel;
                        f  = 1'b1;
                    end else begin
                        x  = imm;
                    end
                end
                OP_ADD: begin
                    ld_en = 1'b1;
                    s1    = SEL_R1;
                    s2    = SEL_R2;
                end
                OP_SUB: begin
                    ld_en = 1'b1;
                    s1    = SEL_R1;
                    s2    = SEL_R2;
                    f     = 1'b1;
                end
                OP_LD: begin
                    ld_en = 1'b1;
                    r     = 1'b1;
                    s1    = SEL_MEM;
                end
                OP_ST: begin
                    // Pass dst through the ALU (dst + 0) into memory.
                    w     = 1'b1;
                    s1    = dst_sel;
                end
                OP_ADDI: begin
                    ld_en = 1'b1;
                    s1    = dst_sel;
                    x     = imm;
                end
                OP_LDINC: begin
                    ld_en = 1'b1;
                    if (!step2) begin
                        r  = 1'b1;
                        s1 = SEL_MEM;
                    end else begin
                        s1 = dst_sel;
                        x  = WIDTH'(1);
                    end
                end
                default: begin
                    // OP_CLRM: 0 + 0 written to mem[AR].
                    w = 1'b1;
                end
            endcase
        end
    end

    assign l1 = ld_en & dst_onehot[0];
    assign l2 = ld_en & dst_onehot[1];
    assign l3 = ld_en & dst_onehot[2];

endmodule

// File: rtl/datapath_sequencer.sv
// Micro-sequencer for the 4-bit register/memory datapath.
// Accepts one command per valid/ready handshake, latches it, and steps
// through 1-2 datapath cycles, then pulses done for one cycle.
//   clk, rst            : clock, synchronous active-high reset
//   cmd_valid/cmd_ready : command handshake (ready only in IDLE)
//   cmd_op/dst/imm      : command fields, latched on accept
//   x,l1,l2,l3,s1,s2,f,w,r : datapath controls (decoded from registered state)
//   done/err            : retire pulse, err=1 for an illegal command
//   retired             : count of commands retired without error (wraps)
module datapath_sequencer
    import datapath_sequencer_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_op,
    input  logic [1:0]         cmd_dst,
    input  logic [WIDTH-1:0]   cmd_imm,
    output logic [WIDTH-1:0]   x,
    output logic               l1,
    output logic               l2,
    output logic               l3,
    output logic [1:0]         s1,
    output logic [1:0]         s2,
    output logic               f,
    output logic               w,
    output logic               r,
    output logic               done,
    output logic               err,
    output logic [CNT_W-1:0]   retired
);

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [1:0]         dst_q, dst_d;
    logic [WIDTH-1:0]   imm_q, imm_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               illegal;

    assign cmd_ready = (state_q == ST_IDLE);
    assign illegal   = cmd_illegal(op_q, dst_q);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        dst_d     = dst_q;
        imm_d     = imm_q;
        retired_d = retired_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d = ST_STEP1;
                    op_d    = cmd_op;
                    dst_d   = cmd_dst;
                    imm_d   = cmd_imm;
                end
            end
            ST_STEP1: begin
                // Illegal commands never take a second step.
                state_d = (!illegal && cmd_two_step(op_q)) ? ST_STEP2 : ST_FIN;
            end
            ST_STEP2: begin
                state_d = ST_FIN;
            end
            default: begin
                state_d = ST_IDLE;
                if (!illegal) begin
                    retired_d = retired_q + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            dst_q     <= '0;
            imm_q     <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            dst_q     <= dst_d;
            imm_q     <= imm_d;
            retired_q <= retired_d;
        end
    end

    datapath_sequencer_seq_decode #(
        .WIDTH (WIDTH)
    ) u_decode (
        .state   (state_q),
        .op      (op_q),
        .dst     (dst_q),
        .imm     (imm_q),
        .illegal (illegal),
        .x       (x),
        .l1      (l1),
        .l2      (l2),
        .l3      (l3),
        .s1      (s1),
        .s2      (s2),
        .f       (f),
        .w       (w),
        .r       (r)
    );

    assign done    = (state_q == ST_FIN);
    assign err     = (state_q == ST_FIN) && illegal;
    assign retired = retired_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed testbench for datapath_sequencer with a behavioural model of the
// R1/R2/AR/memory datapath driven by the sequencer's controls.
module tb_datapath_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [1:0] cmd_dst;
    logic [3:0] cmd_imm;
    logic [3:0] x;
    logic       l1, l2, l3;
    logic [1:0] s1, s2;
    logic       f, w, r;
    logic       done, err;
    logic [7:0] retired;

    int checks = 0;
    int passed = 0;

    datapath_sequencer #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_imm(cmd_imm),
        .x(x), .l1(l1), .l2(l2), .l3(l3), .s1(s1), .s2(s2),
        .f(f), .w(w), .r(r), .done(done), .err(err), .retired(retired)
    );

    always #5 clk = ~clk;

    // Behavioural datapath: two 4:1 muxes into an add/sub ALU.
    logic [3:0] r1_m = 4'd0, r2_m = 4'd0, ar_m = 4'd0;
    logic [3:0] mem_m [16];
    logic [3:0] bus_a, bus_b, alu;

    function automatic logic [3:0] pick(input logic [1:0] sel, input logic [3:0] xv,
                                        input logic [3:0] a1, input logic [3:0] a2,
                                        input logic [3:0] mv);
        case (sel)
            2'd0:    return xv;
            2'd1:    return a1;
            2'd2:    return a2;
            default: return mv;
        endcase
    endfunction

    assign bus_a = pick(s1, x, r1_m, r2_m, mem_m[ar_m]);
    assign bus_b = pick(s2, x, r1_m, r2_m, mem_m[ar_m]);
    assign alu   = f ? (bus_a - bus_b) : (bus_a + bus_b);

    initial begin
        for (int i = 0; i < 16; i++) mem_m[i] = 4'd0;
    end

    always @(posedge clk) begin
        if (l1) r1_m <= alu;
        if (l2) r2_m <= alu;
        if (l3) ar_m <= alu;
        if (w)  mem_m[ar_m] <= alu;
    end

    // Control word {x, l1, l2, l3, s1, s2, f, w, r}
    logic [14:0] cw;
    assign cw = {x, l1, l2, l3, s1, s2, f, w, r};

    function automatic logic [14:0] mk(input logic [3:0] xv, input logic a, input logic b,
                                       input logic c, input logic [1:0] sa, input logic [1:0] sb,
                                       input logic fv, input logic wv, input logic rv);
        return {xv, a, b, c, sa, sb, fv, wv, rv};
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    // Called at a negedge with the sequencer idle. Issues one command, captures
    // the step1/step2 control words and the latency to done, and returns at the
    // negedge of the IDLE cycle that follows done.
    task automatic do_cmd(input string name, input logic [2:0] op, input logic [1:0] dst,
                          input logic [3:0] imm, output int lat, output logic e,
                          output logic [14:0] c1, output logic [14:0] c2);
        check({name, ".ready"}, cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst; cmd_imm = imm;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = -1; e = 1'b0; c1 = '0; c2 = '0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 1) c1 = cw;
            if (i == 2) c2 = cw;
            if (done) begin
                lat = i;
                e = err;
                check({name, ".fin_idle_ctl"}, cw, 0);
                break;
            end
        end
        @(negedge clk);
        $display("cmd %s op=%0d dst=%0d imm=%0d lat=%0d err=%0d step1=%h step2=%h retired=%0d",
                 name, op, dst, imm, lat, e, c1, c2, retired);
    endtask

    int          lat;
    logic        e;
    logic [14:0] c1, c2;

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_dst = '0; cmd_imm = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        check("rst.ready", cmd_ready, 1);
        check("rst.done", done, 0);
        check("rst.err", err, 0);
        check("rst.retired", retired, 0);
        check("rst.ctl", cw, 0);

        // LDI R1,5
        do_cmd("ldi_r1_5", 3'b000, 2'd0, 4'd5, lat, e, c1, c2);
        check("ldi.step1", c1, mk(0, 1, 0, 0, 1, 1, 1, 0, 0));
        check("ldi.step2", c2, mk(5, 1, 0, 0, 1, 0, 0, 0, 0));
        check("ldi.lat", lat, 3);
        check("ldi.err", e, 0);
        check("ldi.r1", r1_m, 5);
        check("ldi.retired", retired, 1);

        do_cmd("ldi_r2_3", 3'b000, 2'd1, 4'd3, lat, e, c1, c2);
        check("ldi2.r2", r2_m, 3);

        do_cmd("sub_r1", 3'b010, 2'd0, 4'd0, lat, e, c1, c2);
        check("sub.step1", c1, mk(0, 1, 0, 0, 1, 2, 1, 0, 0));
        check("sub.lat", lat, 2);
        check("sub.err", e, 0);
        check("sub.r1", r1_m, 2);

        do_cmd("add_r2", 3'b001, 2'd1, 4'd0, lat, e, c1, c2);
        check("add.step1", c1, mk(0, 0, 1, 0, 1, 2, 0, 0, 0));
        check("add.lat", lat, 2);
        check("add.r2", r2_m, 5);

        do_cmd("ldi_r1_4", 3'b000, 2'd0, 4'd4, lat, e, c1, c2);
        do_cmd("ldi_r2_0", 3'b000, 2'd1, 4'd0, lat, e, c1, c2);
        do_cmd("add_ar", 3'b001, 2'd2, 4'd0, lat, e, c1, c2);
        check("addar.step1", c1, mk(0, 0, 0, 1, 1, 2, 0, 0, 0));
        check("addar.ar", ar_m, 4);

        // ST R1: w for exactly one cycle (step2 slot is the idle FIN word)
        do_cmd("st_r1", 3'b100, 2'd0, 4'd0, lat, e, c1, c2);
        check("st.step1", c1, mk(0, 0, 0, 0, 1, 0, 0, 1, 0));
        check("st.after", c2, 0);
        check("st.lat", lat, 2);
        check("st.mem4", mem_m[4], 4);

        do_cmd("ld_r2", 3'b011, 2'd1, 4'd0, lat, e, c1, c2);
        check("ld.step1", c1, mk(0, 0, 1, 0, 3, 0, 0, 0, 1));
        check("ld.r2", r2_m, 4);
        check("ld.retired", retired, 9);

        // Wrap-around arithmetic
        do_cmd("ldi_r1_15", 3'b000, 2'd0, 4'd15, lat, e, c1, c2);
        do_cmd("addi_r1_1", 3'b101, 2'd0, 4'd1, lat, e, c1, c2);
        check("addi.step1", c1, mk(1, 1, 0, 0, 1, 0, 0, 0, 0));
        check("addi.lat", lat, 2);
        check("addi.r1", r1_m, 0);
        do_cmd("ldi_r1_15b", 3'b000, 2'd0, 4'd15, lat, e, c1, c2);
        do_cmd("st_r1_15", 3'b100, 2'd0, 4'd0, lat, e, c1, c2);
        check("st15.mem4", mem_m[4], 15);
        do_cmd("ldinc_r2", 3'b110, 2'd1, 4'd0, lat, e, c1, c2);
        check("ldinc.step1", c1, mk(0, 0, 1, 0, 3, 0, 0, 0, 1));
        check("ldinc.step2", c2, mk(1, 0, 1, 0, 2, 0, 0, 0, 0));
        check("ldinc.lat", lat, 3);
        check("ldinc.r2", r2_m, 0);

        do_cmd("clrm", 3'b111, 2'd0, 4'd0, lat, e, c1, c2);
        check("clrm.step1", c1, mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        check("clrm.mem4", mem_m[4], 0);
        check("clrm.retired", retired, 15);

        // Illegal commands
        do_cmd("add_bad", 3'b001, 2'd3, 4'd0, lat, e, c1, c2);
        check("ill1.step1", c1, 0);
        check("ill1.lat", lat, 2);
        check("ill1.err", e, 1);
        check("ill1.retired", retired, 15);
        do_cmd("addi_ar", 3'b101, 2'd2, 4'd7, lat, e, c1, c2);
        check("ill2.step1", c1, 0);
        check("ill2.err", e, 1);
        check("ill2.ar", ar_m, 4);
        check("ill2.r1", r1_m, 15);
        check("ill2.retired", retired, 15);

        // Reset during STEP1 of LDI
        cmd_valid = 1'b1; cmd_op = 3'b000; cmd_dst = 2'd0; cmd_imm = 4'd9;
        @(posedge clk); #1; cmd_valid = 1'b0;
        @(negedge clk);
        check("rstmid.step1", cw, mk(0, 1, 0, 0, 1, 1, 1, 0, 0));
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("rstmid.ctl", cw, 0);
        check("rstmid.ready", cmd_ready, 1);
        check("rstmid.done", done, 0);
        check("rstmid.retired", retired, 0);
        @(negedge clk);
        check("rstmid.done2", done, 0);
        check("rstmid.ctl2", cw, 0);
        $display("cmd rst_mid_ldi abandoned retired=%0d", retired);

        // cmd_valid held while busy: second command taken only when idle
        cmd_valid = 1'b1; cmd_op = 3'b001; cmd_dst = 2'd0; cmd_imm = 4'd0;
        @(posedge clk); #1;
        cmd_op = 3'b101; cmd_dst = 2'd0; cmd_imm = 4'd1;
        @(negedge clk);
        check("hold.busy_ready1", cmd_ready, 0);
        check("hold.step1", cw, mk(0, 1, 0, 0, 1, 2, 0, 0, 0));
        @(negedge clk);
        check("hold.busy_ready2", cmd_ready, 0);
        check("hold.done", done, 1);
        @(negedge clk);
        check("hold.idle_ready", cmd_ready, 1);
        check("hold.idle_ctl", cw, 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("hold.second_step1", cw, mk(1, 1, 0, 0, 1, 0, 0, 0, 0));
        @(negedge clk);
        check("hold.second_done", done, 1);
        @(negedge clk);
        check("hold.retired", retired, 2);
        $display("cmd held_valid add+addi retired=%0d", retired);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
